// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared definitions for the 7-segment display path: active-low
//             segment patterns, readback FSM states, sizing constants and the
//             shift-add multiply-by-ten helper.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // x*10 as (x<<3)+(x<<1); the accumulator never exceeds 9999
    function automatic logic [VALUE_W-1:0] times_ten(input logic [VALUE_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pattern_decode
//  Purpose  : Combinational active-low segment pattern to BCD digit decoder.
//             Optional macro SEG7_BLANK_EN: an all-off (blank) pattern decodes
//             as a valid 0 so leading-zero suppression reads back correctly.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    // Table lookup; anything outside the table is flagged invalid
    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
`ifdef SEG7_BLANK_EN
            SEG_BLANK: digit = 4'd0;
`endif
            default:   valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Purpose  : Readback monitor for a multiplexed common-anode 7-segment bus.
//             Glitch-filters each digit strobe, collects four digits, then
//             converts BCD to a 14-bit binary value with a sequential
//             multiply-accumulate. Optional macro SEG7_BLANK_EN (in the
//             pattern decoder) accepts blank digits as 0.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_COUNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic [1:0]         digit_select,
    input  logic [6:0]         seg,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic               busy,
    output logic [3:0]         digits_seen,
    output logic               err_invalid,
    output logic               err_sticky
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_COUNT);

    state_t                          state, state_next;
    logic [8:0]                      cand;
    logic [3:0]                      cnt, cnt_next;
    logic                            same, accept;
    logic [3:0]                      dec_digit;
    logic                            dec_valid;
    logic [3:0]                      seen_next;
    logic [NUM_DIGITS-1:0][3:0]      digits;
    logic [1:0]                      step;
    logic [VALUE_W-1:0]              acc, acc_next;

    seg7_pattern_decode u_decode (
        .seg   (seg),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    assign busy = (state != COLLECT);

    // Stability count and acceptance; a saturated count never re-accepts
    always_comb begin
        same     = (cand == {digit_select, seg});
        cnt_next = 4'd1;
        if (same) begin
            cnt_next = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end
        accept    = sample_en && (state == COLLECT) && (cnt_next == STABLE_CNT)
                    && !(same && (cnt == STABLE_CNT));
        seen_next = digits_seen;
        if (accept) begin
            seen_next[digit_select] = dec_valid;
        end
        acc_next = times_ten(acc) + VALUE_W'(digits[~step]);
    end

    // Next-state logic: frame complete -> four MAC steps -> one DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (seen_next == 4'b1111) state_next = CONVERT;
            CONVERT: if (step == 2'd3)         state_next = DONE;
            DONE:                              state_next = COLLECT;
            default:                           state_next = COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    // Tracker: updates only on strobes in COLLECT, wiped when a frame retires
    always_ff @(posedge clk) begin
        if (rst || state == DONE) begin
            cand <= 9'd0;
            cnt  <= 4'd0;
        end else if (sample_en && state == COLLECT) begin
            cand <= {digit_select, seg};
            cnt  <= cnt_next;
        end
    end

    // Digit capture, seen mask and error reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            digits      <= '0;
            digits_seen <= 4'd0;
            err_invalid <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            err_invalid <= accept && !dec_valid;
            if (accept && !dec_valid) err_sticky <= 1'b1;
            if (accept && dec_valid) digits[digit_select] <= dec_digit;
            digits_seen <= (state == DONE) ? 4'd0 : seen_next;
        end
    end

    // BCD-to-binary MAC, thousands digit first
    always_ff @(posedge clk) begin
        if (rst) begin
            step        <= 2'd0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (state == CONVERT) begin
                acc  <= acc_next;
                step <= step + 2'd1;
                if (step == 2'd3) begin
                    value       <= acc_next;
                    value_valid <= 1'b1;
                end
            end else begin
                acc  <= '0;
                step <= 2'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Purpose  : Self-checking bench for seg7_scan_decoder against a decimal
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [1:0]  digit_select = 2'd0;
    logic [6:0]  seg = 7'h7F;
    logic [13:0] value;
    logic        value_valid, busy, err_invalid, err_sticky;
    logic [3:0]  digits_seen;

    seg7_scan_decoder #(.STABLE_COUNT(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .digit_select (digit_select),
        .seg          (seg),
        .value        (value),
        .value_valid  (value_valid),
        .busy         (busy),
        .digits_seen  (digits_seen),
        .err_invalid  (err_invalid),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [6:0] pat_tab [10];

    // Reference model state
    int         cyc = 0;
    logic [8:0] m_cand;
    int         m_cnt;
    int         m_d [4];
    logic [3:0] m_seen;
    bit         frame_on;
    int         e_edge;
    int         pending;
    int         e_value;
    bit         e_vv, e_err, e_sticky;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (s == pat_tab[i]) return i;
`ifdef SEG7_BLANK_EN
        if (s == 7'b1111111) return 0;
`endif
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic [1:0] ds, input logic [6:0] sg);
        int  rel, old, d;
        bit  diff;
        cyc++;
        e_vv  = 0;
        e_err = 0;
        if (r) begin
            m_cand = '0; m_cnt = 0; m_seen = '0; frame_on = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 0;
            e_value = 0; e_sticky = 0;
            return;
        end
        rel = frame_on ? (cyc - e_edge) : -1;
        if (frame_on && rel >= 1 && rel <= 5) begin
            if (rel == 4) begin e_value = pending; e_vv = 1; end
            if (rel == 5) begin frame_on = 0; m_seen = '0; m_cand = '0; m_cnt = 0; end
        end else if (en) begin
            old  = m_cnt;
            diff = ({ds, sg} != m_cand);
            if (diff) begin m_cand = {ds, sg}; m_cnt = 1; end
            else if (m_cnt < 15) m_cnt = m_cnt + 1;
            if (m_cnt == SC && (diff || m_cnt != old)) begin
                d = decode(sg);
                if (d >= 0) begin
                    m_d[ds] = d;
                    m_seen[ds] = 1'b1;
                end else begin
                    m_seen[ds] = 1'b0;
                    e_err = 1; e_sticky = 1;
                end
                if (m_seen == 4'b1111) begin
                    frame_on = 1;
                    e_edge   = cyc;
                    pending  = m_d[3]*1000 + m_d[2]*100 + m_d[1]*10 + m_d[0];
                end
            end
        end
    endtask

    task automatic drv(input logic r, input logic en, input logic [1:0] ds, input logic [6:0] sg);
        @(negedge clk);
        rst = r; sample_en = en; digit_select = ds; seg = sg;
        @(posedge clk);
        model_edge(r, en, ds, sg);
        #1;
        check("value",       int'(value),       e_value);
        check("value_valid", int'(value_valid), int'(e_vv));
        check("busy",        int'(busy),        int'(frame_on && (cyc - e_edge) <= 4));
        check("digits_seen", int'(digits_seen), int'(m_seen));
        check("err_invalid", int'(err_invalid), int'(e_err));
        check("err_sticky",  int'(err_sticky),  int'(e_sticky));
    endtask

    task automatic strobe2(input logic [1:0] ds, input logic [6:0] sg);
        drv(1'b0, 1'b1, ds, sg);
        drv(1'b0, 1'b1, ds, sg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 2'd0, 7'h7F);
    endtask

    initial begin
        pat_tab[0] = 7'b1000000; pat_tab[1] = 7'b1111001; pat_tab[2] = 7'b0100100;
        pat_tab[3] = 7'b0110000; pat_tab[4] = 7'b0011001; pat_tab[5] = 7'b0010010;
        pat_tab[6] = 7'b0000010; pat_tab[7] = 7'b1111000; pat_tab[8] = 7'b0000000;
        pat_tab[9] = 7'b0010000;

        // Reset state
        drv(1'b1, 1'b0, 2'd0, 7'h7F);
        drv(1'b1, 1'b0, 2'd0, 7'h7F);

        // 1234
        strobe2(2'd0, 7'b0011001);
        strobe2(2'd1, 7'b0110000);
        strobe2(2'd2, 7'b0100100);
        strobe2(2'd3, 7'b1111001);
        idle(6);
        check("value_1234", int'(value), 1234);

        // Glitched digit 1 settles on 5 -> 50
        strobe2(2'd0, 7'b1000000);
        strobe2(2'd2, 7'b1000000);
        strobe2(2'd3, 7'b1000000);
        drv(1'b0, 1'b1, 2'd1, 7'b0110000);
        strobe2(2'd1, 7'b0010010);
        idle(6);
        check("value_50", int'(value), 50);

        // Invalid pattern, then 9999
        strobe2(2'd2, 7'b1010101);
        check("sticky_set", int'(err_sticky), 1);
        strobe2(2'd0, 7'b0010000);
        strobe2(2'd1, 7'b0010000);
        strobe2(2'd2, 7'b0010000);
        strobe2(2'd3, 7'b0010000);
        idle(6);
        check("value_9999", int'(value), 9999);
        check("sticky_held", int'(err_sticky), 1);

        // Blank thousands digit with 0,0,7
        strobe2(2'd0, 7'b1000000);
        strobe2(2'd1, 7'b1000000);
        strobe2(2'd2, 7'b1111000);
        strobe2(2'd3, 7'b1111111);
        idle(6);
`ifdef SEG7_BLANK_EN
        check("value_700", int'(value), 700);
`else
        check("blank_no_conv", int'(value), 9999);
`endif
        drv(1'b1, 1'b0, 2'd0, 7'h7F);

        // Frame, then new patterns while busy are ignored
        strobe2(2'd0, 7'b0000010);
        strobe2(2'd1, 7'b1111000);
        strobe2(2'd2, 7'b0000000);
        strobe2(2'd3, 7'b0010010);
        for (int i = 0; i < 5; i++) drv(1'b0, 1'b1, 2'(i), 7'b1111001);
        drv(1'b0, 1'b1, 2'd0, 7'b1111001);
        idle(3);
        check("value_5876", int'(value), 5876);

        // Reset mid-conversion at edge E+2, then a full frame
        strobe2(2'd0, 7'b0110000);
        strobe2(2'd1, 7'b0110000);
        strobe2(2'd2, 7'b0110000);
        strobe2(2'd3, 7'b0110000);
        idle(1);
        drv(1'b1, 1'b0, 2'd0, 7'h7F);
        idle(4);
        check("abort_value", int'(value), 0);
        strobe2(2'd3, 7'b0011001);
        strobe2(2'd2, 7'b1000000);
        strobe2(2'd1, 7'b0000010);
        strobe2(2'd0, 7'b1111001);
        idle(6);
        check("value_4061", int'(value), 4061);

        // Randomized traffic
        for (int g = 0; g < 400; g++) begin
            logic [1:0] ds;
            logic [6:0] sg;
            int reps;
            ds   = 2'($urandom_range(0, 3));
            sg   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pat_tab[$urandom_range(0, 9)];
            reps = $urandom_range(1, 3);
            if ($urandom_range(0, 99) == 0) drv(1'b1, 1'b0, 2'd0, 7'h7F);
            for (int k = 0; k < reps; k++) begin
                if ($urandom_range(0, 4) == 0) drv(1'b0, 1'b0, 2'($urandom), 7'($urandom));
                drv(1'b0, 1'b1, ds, sg);
            end
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
